// File: rtl/bp_hidden_weight_updater.sv
// Sequencer for backprop step 2: walks every input->hidden weight, presents its operand
// set, waits out the step-2 latency and writes w_new back into the w1 bank in place.
module bp_hidden_weight_updater #(
   parameter int unsigned N_IN     = 4,
   parameter int unsigned N_HID    = 4,
   parameter int unsigned PIPE_LAT = 8,
   parameter int unsigned AW       = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          done,
   input  logic [31:0]   target,
   input  logic [31:0]   sigmoid_out,
   input  logic [31:0]   out_value,
   input  logic          load_en,
   input  logic [1:0]    load_sel,
   input  logic [AW-1:0] load_addr,
   input  logic [31:0]   load_data,
   input  logic [AW-1:0] rd_addr,
   output logic [31:0]   rd_data,
   output logic [31:0]   s2_target,
   output logic [31:0]   s2_sigmoid_out,
   output logic [31:0]   s2_out_value,
   output logic [31:0]   s2_layer2_weight,
   output logic [31:0]   s2_hidden_value,
   output logic [31:0]   s2_initial_input,
   output logic [31:0]   s2_initial_weight,
   input  logic [31:0]   s2_w_new
);

   localparam int unsigned NW  = N_IN * N_HID;
   localparam int unsigned WCW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

   typedef enum logic [2:0] {S_IDLE, S_PRESENT, S_WAIT, S_WRITE, S_DONE} state_e;
   state_e state_q, state_d;

   logic [31:0] x_q  [N_IN];
   logic [31:0] x_d  [N_IN];
   logic [31:0] h_q  [N_HID];
   logic [31:0] h_d  [N_HID];
   logic [31:0] w2_q [N_HID];
   logic [31:0] w2_d [N_HID];
   logic [31:0] w1_q [NW];
   logic [31:0] w1_d [NW];

   logic [AW-1:0]  k_q, k_d;
   logic [WCW-1:0] wcnt_q, wcnt_d;
   logic [31:0]    tgt_q, tgt_d, sig_q, sig_d, outv_q, outv_d;
   logic [31:0]    w2op_q, w2op_d, hop_q, hop_d, xop_q, xop_d, w1op_q, w1op_d;
   logic [31:0]    rd_q, rd_d;
   logic           ld_ops, last_k;

   assign last_k = (k_q == AW'(NW - 1));

   always_ff @(posedge clk) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (start) state_d = S_PRESENT;
         S_PRESENT: state_d = S_WAIT;
         S_WAIT:    if (wcnt_q == '0) state_d = S_WRITE;
         S_WRITE:   state_d = last_k ? S_DONE : S_PRESENT;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q != S_IDLE);
      done = (state_q == S_DONE);
   end

   // Banks see the IDLE load and the WRITE-back this cycle, so operands read here are current.
   always_comb begin
      x_d  = x_q;
      h_d  = h_q;
      w2_d = w2_q;
      w1_d = w1_q;
      if (load_en && state_q == S_IDLE) begin
         for (int unsigned n = 0; n < N_IN; n++)
            if (load_sel == 2'd0 && load_addr == AW'(n)) x_d[n] = load_data;
         for (int unsigned n = 0; n < N_HID; n++) begin
            if (load_sel == 2'd1 && load_addr == AW'(n)) h_d[n]  = load_data;
            if (load_sel == 2'd2 && load_addr == AW'(n)) w2_d[n] = load_data;
         end
         for (int unsigned n = 0; n < NW; n++)
            if (load_sel == 2'd3 && load_addr == AW'(n)) w1_d[n] = load_data;
      end
      if (state_q == S_WRITE)
         for (int unsigned n = 0; n < NW; n++)
            if (k_q == AW'(n)) w1_d[n] = s2_w_new;
   end

   always_comb begin
      k_d    = k_q;
      wcnt_d = wcnt_q;
      tgt_d  = tgt_q;
      sig_d  = sig_q;
      outv_d = outv_q;
      ld_ops = 1'b0;
      unique case (state_q)
         S_IDLE: if (start) begin
            k_d    = '0;
            tgt_d  = target;
            sig_d  = sigmoid_out;
            outv_d = out_value;
            ld_ops = 1'b1;
         end
         S_PRESENT: wcnt_d = WCW'(PIPE_LAT - 1);
         S_WAIT:    if (wcnt_q != '0) wcnt_d = wcnt_q - WCW'(1);
         S_WRITE: if (!last_k) begin
            k_d    = k_q + AW'(1);
            ld_ops = 1'b1;
         end
         default: ;
      endcase

      xop_d  = xop_q;
      hop_d  = hop_q;
      w2op_d = w2op_q;
      w1op_d = w1op_q;
      if (ld_ops)
         for (int unsigned n = 0; n < NW; n++)
            if (k_d == AW'(n)) begin
               xop_d  = x_d[n % N_IN];
               hop_d  = h_d[n / N_IN];
               w2op_d = w2_d[n / N_IN];
               w1op_d = w1_d[n];
            end

      rd_d = '0;
      for (int unsigned n = 0; n < NW; n++)
         if (rd_addr == AW'(n)) rd_d = w1_d[n];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_q    <= '{default: '0};
         h_q    <= '{default: '0};
         w2_q   <= '{default: '0};
         w1_q   <= '{default: '0};
         k_q    <= '0;
         wcnt_q <= '0;
         tgt_q  <= '0;
         sig_q  <= '0;
         outv_q <= '0;
         w2op_q <= '0;
         hop_q  <= '0;
         xop_q  <= '0;
         w1op_q <= '0;
         rd_q   <= '0;
      end else begin
         x_q    <= x_d;
         h_q    <= h_d;
         w2_q   <= w2_d;
         w1_q   <= w1_d;
         k_q    <= k_d;
         wcnt_q <= wcnt_d;
         tgt_q  <= tgt_d;
         sig_q  <= sig_d;
         outv_q <= outv_d;
         w2op_q <= w2op_d;
         hop_q  <= hop_d;
         xop_q  <= xop_d;
         w1op_q <= w1op_d;
         rd_q   <= rd_d;
      end
   end

   assign rd_data           = rd_q;
   assign s2_target         = tgt_q;
   assign s2_sigmoid_out    = sig_q;
   assign s2_out_value      = outv_q;
   assign s2_layer2_weight  = w2op_q;
   assign s2_hidden_value   = hop_q;
   assign s2_initial_input  = xop_q;
   assign s2_initial_weight = w1op_q;

endmodule

// File: tb/tb_bp_hidden_weight_updater.sv
// Directed bench for bp_hidden_weight_updater: default 4x4/PIPE_LAT=8 build plus a 1x1/PIPE_LAT=1 build,
// each with a sign-flipping step-2 stub delayed by PIPE_LAT cycles.
module tb_bp_hidden_weight_updater;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, load_en, busy, done;
   logic [1:0]  load_sel;
   logic [3:0]  load_addr, rd_addr;
   logic [31:0] target, sigmoid_out, out_value, load_data, rd_data, s2_w_new;
   logic [31:0] s2_target, s2_sigmoid_out, s2_out_value, s2_layer2_weight;
   logic [31:0] s2_hidden_value, s2_initial_input, s2_initial_weight;

   logic        b_start, b_load_en, b_busy, b_done;
   logic [0:0]  b_load_addr, b_rd_addr;
   logic [31:0] b_rd_data, b_w_new;
   logic [31:0] b_target, b_sigmoid_out, b_out_value, b_layer2_weight;
   logic [31:0] b_hidden_value, b_initial_input, b_initial_weight;

   int tests = 0;
   int fails = 0;
   int n, dones;
   logic [31:0] v;

   bp_hidden_weight_updater #(.N_IN(4), .N_HID(4), .PIPE_LAT(8), .AW(4)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .target(target), .sigmoid_out(sigmoid_out), .out_value(out_value),
      .load_en(load_en), .load_sel(load_sel), .load_addr(load_addr), .load_data(load_data),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .s2_target(s2_target), .s2_sigmoid_out(s2_sigmoid_out), .s2_out_value(s2_out_value),
      .s2_layer2_weight(s2_layer2_weight), .s2_hidden_value(s2_hidden_value),
      .s2_initial_input(s2_initial_input), .s2_initial_weight(s2_initial_weight),
      .s2_w_new(s2_w_new)
   );

   bp_hidden_weight_updater #(.N_IN(1), .N_HID(1), .PIPE_LAT(1), .AW(1)) dut1 (
      .clk(clk), .reset(reset), .start(b_start), .busy(b_busy), .done(b_done),
      .target(target), .sigmoid_out(sigmoid_out), .out_value(out_value),
      .load_en(b_load_en), .load_sel(load_sel), .load_addr(b_load_addr), .load_data(load_data),
      .rd_addr(b_rd_addr), .rd_data(b_rd_data),
      .s2_target(b_target), .s2_sigmoid_out(b_sigmoid_out), .s2_out_value(b_out_value),
      .s2_layer2_weight(b_layer2_weight), .s2_hidden_value(b_hidden_value),
      .s2_initial_input(b_initial_input), .s2_initial_weight(b_initial_weight),
      .s2_w_new(b_w_new)
   );

   // Step-2 stubs: flip the sign of the presented weight, PIPE_LAT cycles later.
   logic [31:0] pipe [8];
   always_ff @(posedge clk) begin
      pipe[0] <= s2_initial_weight ^ 32'h8000_0000;
      for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
      b_w_new <= b_initial_weight ^ 32'h8000_0000;
   end
   assign s2_w_new = pipe[7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic load(input logic [1:0] sel, input logic [3:0] a, input logic [31:0] d);
      load_en = 1'b1; load_sel = sel; load_addr = a; load_data = d;
      tick();
      load_en = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] val);
      rd_addr = a;
      tick();
      val = rd_data;
   endtask

   task automatic start_pass();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Cycle index relative to the start cycle; capped so a missing done cannot hang the run.
   task automatic wait_done(input int from, output int cyc);
      cyc = from;
      while (done !== 1'b1 && cyc < 400) begin
         tick();
         cyc++;
      end
   endtask

   task automatic count_done(input int cycles, output int cnt);
      cnt = 0;
      repeat (cycles) begin
         tick();
         if (done === 1'b1) cnt++;
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; load_en = 1'b0; load_sel = 2'd0; load_addr = '0;
      load_data = '0; rd_addr = '0; target = 32'h3F80_0000; sigmoid_out = 32'h3F00_0000;
      out_value = 32'h4000_0000; b_start = 1'b0; b_load_en = 1'b0; b_load_addr = '0;
      b_rd_addr = '0;
      tick(); tick();
      reset = 1'b0;

      // 1: reset state
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_rd_data", rd_data, 32'h0);
      check("rst_s2_target", s2_target, 32'h0);
      check("rst_s2_sigmoid", s2_sigmoid_out, 32'h0);
      check("rst_s2_outval", s2_out_value, 32'h0);
      check("rst_s2_w2", s2_layer2_weight, 32'h0);
      check("rst_s2_h", s2_hidden_value, 32'h0);
      check("rst_s2_x", s2_initial_input, 32'h0);
      check("rst_s2_w1", s2_initial_weight, 32'h0);
      check("rst_b_busy", 32'(b_busy), 32'd0);
      for (int k = 0; k < 16; k++) begin
         rd(4'(k), v);
         check($sformatf("rst_w1[%0d]", k), v, 32'h0);
      end

      // 2: full pass with sign-flip stub
      for (int k = 0; k < 16; k++) load(2'd3, 4'(k), 32'h3F80_0000 + 32'(k));
      start_pass();
      check("p2_busy_after_start", 32'(busy), 32'd1);
      wait_done(1, n);
      check("p2_latency", 32'(n), 32'd161);
      tick();
      check("p2_done_drop", 32'(done), 32'd0);
      check("p2_busy_drop", 32'(busy), 32'd0);
      for (int k = 0; k < 16; k++) begin
         rd(4'(k), v);
         check($sformatf("p2_w1[%0d]", k), v, 32'hBF80_0000 + 32'(k));
      end

      // 3: operand routing for k=9 (j=2, i=1)
      load(2'd0, 4'd1, 32'h4000_0000);
      load(2'd1, 4'd2, 32'h3F00_0000);
      load(2'd2, 4'd2, 32'h3E80_0000);
      target = 32'h3F00_0001;
      start_pass();
      target = 32'h0;
      repeat (90) tick();
      check("k9_present_x", s2_initial_input, 32'h4000_0000);
      check("k9_present_h", s2_hidden_value, 32'h3F00_0000);
      check("k9_present_w2", s2_layer2_weight, 32'h3E80_0000);
      check("k9_present_w1", s2_initial_weight, 32'hBF80_0009);
      repeat (8) tick();
      check("k9_wait_x", s2_initial_input, 32'h4000_0000);
      check("k9_wait_h", s2_hidden_value, 32'h3F00_0000);
      check("k9_wait_w2", s2_layer2_weight, 32'h3E80_0000);
      check("k9_target", s2_target, 32'h3F00_0001);
      check("k9_sigmoid", s2_sigmoid_out, 32'h3F00_0000);
      wait_done(99, n);
      check("p3_latency", 32'(n), 32'd161);
      tick();
      check("idle_hold_w1", s2_initial_weight, 32'hBF80_000F);
      check("idle_hold_target", s2_target, 32'h3F00_0001);

      // 4: start and load ignored while busy
      start_pass();
      repeat (4) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      load_en = 1'b1; load_sel = 2'd3; load_addr = 4'd0; load_data = 32'h0;
      tick();
      load_en = 1'b0;
      wait_done(7, n);
      check("p4_latency", 32'(n), 32'd161);
      count_done(30, dones);
      check("p4_done_once", 32'(dones), 32'd0);
      check("p4_busy_idle", 32'(busy), 32'd0);
      rd(4'd0, v);
      check("p4_w1[0]", v, 32'hBF80_0000);
      rd(4'd5, v);
      check("p4_w1[5]", v, 32'hBF80_0005);

      // 5: reset mid-pass, then a clean pass with same-cycle load+start
      start_pass();
      repeat (49) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_s2_w1", s2_initial_weight, 32'h0);
      count_done(200, dones);
      check("abort_no_done", 32'(dones), 32'd0);
      for (int k = 0; k < 16; k++) begin
         rd(4'(k), v);
         check($sformatf("abort_w1[%0d]", k), v, 32'h0);
      end
      load(2'd3, 4'd3, 32'h1234_5678);
      load_en = 1'b1; load_sel = 2'd3; load_addr = 4'd0; load_data = 32'h4040_0000;
      start = 1'b1;
      tick();
      start = 1'b0; load_en = 1'b0;
      wait_done(1, n);
      check("p5_latency", 32'(n), 32'd161);
      tick();
      rd(4'd0, v);
      check("p5_w1[0]_same_cycle_load", v, 32'hC040_0000);
      rd(4'd3, v);
      check("p5_w1[3]", v, 32'h9234_5678);
      rd(4'd1, v);
      check("p5_w1[1]", v, 32'h8000_0000);

      // 6: 1x1 build with PIPE_LAT=1
      b_load_en = 1'b1; load_sel = 2'd3; b_load_addr = 1'b0; load_data = 32'h4120_0000;
      tick();
      b_load_en = 1'b0;
      b_start = 1'b1;
      tick();
      b_start = 1'b0;
      check("b_busy_after_start", 32'(b_busy), 32'd1);
      n = 1;
      while (b_done !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      check("b_latency", 32'(n), 32'd4);
      b_rd_addr = 1'b0;
      tick();
      check("b_w1[0]", b_rd_data, 32'hC120_0000);
      b_rd_addr = 1'b1;
      tick();
      check("b_rd_out_of_range", b_rd_data, 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
